rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port (we/wR/wD) between two writeback sources:
//  - req0: the in-order pipeline WB stage.
//  - req1: a long-latency unit (mul/div/load miss).

---
 rtl/rf_wport_arbiter.sv | 138 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single register-file write port between the
// in-order WB stage (req0) and a long-latency unit (req1). req0 has fixed
// priority; a starvation counter forces a req1 grant after STARVE_MAX
// consecutive denied cycles. The write port itself is registered.
//
// Optional feature: define RF_WPORT_SCOREBOARD_EN to add the pending-write
// scoreboard that drives busy1/busy2. Without it busy1/busy2 are tied to 0.
module rf_wport_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_wR,
    input  logic [DW-1:0] req0_wD,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_wR,
    input  logic [DW-1:0] req1_wD,
    output logic          rf_we,
    output logic [AW-1:0] rf_wR,
    output logic [DW-1:0] rf_wD,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_rd,
    input  logic [AW-1:0] rR1,
    input  logic [AW-1:0] rR2,
    output logic          busy1,
    output logic          busy2
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve;
    logic          r_we;
    logic [AW-1:0] r_wR;
    logic [DW-1:0] r_wD;

    logic          w_force;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [AW-1:0] w_sel_wR;
    logic [DW-1:0] w_sel_wD;
    logic          w_wr_en;

    // Grant decision: forced req1 when starved, otherwise req0 first, then req1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_force  = 1'b0;
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_sel_wR = req0_wR;
        w_sel_wD = req0_wD;
        if (!rst) begin
            w_force = req1_valid && (r_starve == STARVE_LIM);
            w_gnt1  = req1_valid && (w_force || !req0_valid);
            w_gnt0  = req0_valid && !w_force;
        end
        if (w_gnt1) begin
            w_sel_wR = req1_wR;
            w_sel_wD = req1_wD;
        end
    end

    // A granted write to x0 still completes its handshake but never reaches the RF.
    assign w_wr_en    = (w_gnt0 || w_gnt1) && (w_sel_wR != '0);
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Registered write port: index/data only move on an effective write.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            r_we <= 1'b0;
            r_wR <= '0;
            r_wD <= '0;
        end else begin
            r_we <= w_wr_en;
            if (w_wr_en) begin
                r_wR <= w_sel_wR;
                r_wD <= w_sel_wD;
            end
        end
    end

    assign rf_we = r_we;
    assign rf_wR = r_wR;
    assign rf_wD = r_wD;

    // Starvation counter: counts consecutive cycles req1 waits behind req0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!req1_valid || w_gnt1) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_LIM) begin
            r_starve <= r_starve + 1'b1;
        end
    end

`ifdef RF_WPORT_SCOREBOARD_EN
    logic [2**AW-1:0] r_pending;
    logic [2**AW-1:0] w_pending_nxt;

    // Pending update: req1 handshake clears its index, a new issue sets one (set wins).
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_gnt1) begin
            w_pending_nxt[req1_wR] = 1'b0;
        end
        if (sb_set && (sb_rd != '0)) begin
            w_pending_nxt[sb_rd] = 1'b1;
        end
    end

    // Pending vector register; a small flop vector, so it is cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign busy1 = r_pending[rR1];
    assign busy2 = r_pending[rR2];
`else
    logic w_unused_sb;

    assign w_unused_sb = ^{sb_set, sb_rd, rR1, rR2};
    assign busy1       = 1'b0;
    assign busy2       = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Testbench for rf_wport_arbiter: directed checks pinning the grant pattern,
// latency, x0 behaviour, reset and scoreboard, followed by randomized traffic
// compared every cycle against a behavioural model.
module tb_rf_wport_arbiter;

    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_wR;
    logic [DW-1:0] req0_wD;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_wR;
    logic [DW-1:0] req1_wD;
    logic          rf_we;
    logic [AW-1:0] rf_wR;
    logic [DW-1:0] rf_wD;
    logic          sb_set;
    logic [AW-1:0] sb_rd;
    logic [AW-1:0] rR1, rR2;
    logic          busy1, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wport_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_wR(req0_wR), .req0_wD(req0_wD),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_wR(req1_wR), .req1_wD(req1_wD),
        .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .rR1(rR1), .rR2(rR2),
        .busy1(busy1), .busy2(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // streak: consecutive cycles req1 has been waiting while req0 was served.
    // e_*: what the write port must show at the next sample.
    int            streak = 0;
    logic          e_we   = 1'b0;
    logic [AW-1:0] e_wR   = '0;
    logic [DW-1:0] e_wD   = '0;
    bit            pend [2**AW];

    always @(negedge clk) begin : model_cmp
        logic          g0, g1;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        if (rst) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rf_we",  rf_we, 0);
            check("rst_rf_wR",  rf_wR, 0);
            check("rst_rf_wD",  rf_wD, 0);
            check("rst_busy1",  busy1, 0);
            check("rst_busy2",  busy2, 0);
            streak = 0;
            e_we   = 1'b0;
            e_wR   = '0;
            e_wD   = '0;
            for (int i = 0; i < 2**AW; i++) pend[i] = 1'b0;
        end else begin
            g1 = req1_valid && (streak >= STARVE_MAX || !req0_valid);
            g0 = req0_valid && !g1;
            check("m_ready0", req0_ready, g0);
            check("m_ready1", req1_ready, g1);
            check("m_rf_we",  rf_we, e_we);
            check("m_rf_wR",  rf_wR, e_wR);
            check("m_rf_wD",  rf_wD, e_wD);
`ifdef RF_WPORT_SCOREBOARD_EN
            check("m_busy1", busy1, pend[rR1]);
            check("m_busy2", busy2, pend[rR2]);
`else
            check("m_busy1", busy1, 0);
            check("m_busy2", busy2, 0);
`endif
            // Effect of the coming rising edge.
            wr = g1 ? req1_wR : req0_wR;
            wd = g1 ? req1_wD : req0_wD;
            e_we = (g0 || g1) && (wr != 0);
            if (e_we) begin
                e_wR = wr;
                e_wD = wd;
            end
            if (req1_valid && !g1) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
            else                   streak = 0;
            if (g1) pend[req1_wR] = 1'b0;
            if (sb_set && sb_rd != 0) pend[sb_rd] = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    bit hold0, hold1;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_wR = '0; req0_wD = '0;
        req1_valid = 0; req1_wR = '0; req1_wD = '0;
        sb_set = 0; sb_rd = '0; rR1 = '0; rR2 = '0;
        step(); step();

        // Reset held with a live req0: nothing granted, nothing written.
        req0_valid = 1; req0_wR = 5'd3; req0_wD = 32'h0000_0011;
        @(negedge clk);
        check("t1_ready_in_rst", req0_ready, 0);
        check("t1_we_in_rst", rf_we, 0);
        check("t1_busy_in_rst", busy1, 0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("t1_ready_after_rel", req0_ready, 1);
        check("t1_we_same_cycle", rf_we, 0);
        step(); req0_valid = 0;
        @(negedge clk);
        check("t1_we_next", rf_we, 1);
        check("t1_wR_next", rf_wR, 3);

        // Single req0 write with one cycle latency.
        step(); req0_valid = 1; req0_wR = 5'd5; req0_wD = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t2_ready0", req0_ready, 1);
        step(); req0_valid = 0;
        @(negedge clk);
        check("t2_we", rf_we, 1);
        check("t2_wR", rf_wR, 5);
        check("t2_wD", rf_wD, 32'hDEAD_BEEF);

        // x0 write: handshake yes, write no, port holds previous index/data.
        step(); req0_valid = 1; req0_wR = '0; req0_wD = 32'h0000_1234;
        @(negedge clk);
        check("t4_ready0", req0_ready, 1);
        step(); req0_valid = 0;
        @(negedge clk);
        check("t4_we", rf_we, 0);
        check("t4_wD_held", rf_wD, 32'hDEAD_BEEF);

        // Both valid continuously: 4 req0 grants then 1 req1 grant, repeating.
        step();
        req0_valid = 1; req0_wR = 5'd2; req0_wD = 32'hA;
        req1_valid = 1; req1_wR = 5'd9; req1_wD = 32'hB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_gnt1", req1_ready, (i % 5) == 4);
            check("t3_gnt0", req0_ready, (i % 5) != 4);
            step();
        end
        req0_valid = 0; req1_valid = 0;

        // Reset while req1 has waited 3 cycles: counter restarts from zero.
        step(); req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_wait", req1_ready, 0);
            step();
        end
        rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_after_rst", req1_ready, i == 4);
            step();
        end
        req0_valid = 0; req1_valid = 0;

`ifdef RF_WPORT_SCOREBOARD_EN
        // Scoreboard: set, clear on req1 write, and set-wins on collision.
        sb_set = 1; sb_rd = 5'd7; rR1 = 5'd7;
        step(); sb_set = 0;
        @(negedge clk);
        check("t5_busy_set", busy1, 1);
        step(); req1_valid = 1; req1_wR = 5'd7; req1_wD = 32'h77;
        @(negedge clk);
        check("t5_ready1", req1_ready, 1);
        step(); req1_valid = 0;
        @(negedge clk);
        check("t5_busy_clr", busy1, 0);
        check("t5_we", rf_we, 1);
        check("t5_wR", rf_wR, 7);
        step(); sb_set = 1;
        step(); req1_valid = 1;
        @(negedge clk);
        check("t5_busy_pre", busy1, 1);
        step(); sb_set = 0; req1_valid = 0;
        @(negedge clk);
        check("t5_set_wins", busy1, 1);
`else
        // No scoreboard: issue indications are ignored.
        sb_set = 1; sb_rd = 5'd7; rR1 = 5'd7;
        step(); sb_set = 0;
        @(negedge clk);
        check("t6_busy_off", busy1, 0);
`endif

        // Randomized traffic; held requests stay stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hold0 = req0_valid && !req0_ready;
            hold1 = req1_valid && !req1_ready;
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (!hold0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_wR    = AW'($urandom_range(0, 2**AW - 1));
                req0_wD    = $urandom;
            end
            if (!hold1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_wR    = AW'($urandom_range(0, 2**AW - 1));
                req1_wD    = $urandom;
            end
            sb_set = ($urandom_range(0, 3) == 0);
            sb_rd  = AW'($urandom_range(0, 2**AW - 1));
            rR1    = AW'($urandom_range(0, 2**AW - 1));
            rR2    = AW'($urandom_range(0, 2**AW - 1));
        end

        req0_valid = 0; req1_valid = 0; sb_set = 0; rst = 0;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
